// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM encodings, response codes, beat layout.
package bridge_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int WRITE_W = 1;

  // Queued beat layout, MSB first: {write, addr, data}
  function automatic int beat_width(input int addr_w, input int data_w);
    return WRITE_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Request FIFO between the AHB capture stage and the APB sequencer.
// Push/pop gating is owned by the caller; this block only keeps the ring.
module apb_req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/apb_controller.sv
// APB side of the AHB-to-APB bridge: queues incoming beats and replays each
// one as an APB3 SETUP/ACCESS transfer, returning read data and error pulses.
//
// state     | meaning
// ST_IDLE   | no transfer; waits for a queued beat
// ST_SETUP  | Psel asserted, Penable low, beat just popped
// ST_ACCESS | Penable high; waits for Pready or timeout
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr_temp,
  input  logic [DATA_W-1:0] Hwdata_temp,
  input  logic              Hwrite_temp,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr,
  output logic [NSLV-1:0]   Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic              rd_valid,
  output logic              Hresp,
  output logic              Hready_out,
  output logic              overflow
);

  localparam int BEAT_W = beat_width(ADDR_W, DATA_W);
  localparam int IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] HR_LIM  = CNT_W'(DEPTH - 1);
  localparam logic [WC_W-1:0]  WC_ONE  = 1;
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              push, pop, full, empty;
  logic [BEAT_W-1:0] head;
  logic [CNT_W-1:0]  fifo_count, count_nxt;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [IDX_W-1:0]  idx;
  logic              done, abort;

  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic              rd_valid_q, rd_valid_d, hresp_q, hresp_d;
  logic              hready_q, hready_d, overflow_q, overflow_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;

  apb_req_fifo #(.WIDTH(BEAT_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (Hclk),
    .rst_n_i (Hresetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({Hwrite_temp, Haddr_temp, Hwdata_temp}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign head_write = head[BEAT_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_data  = head[DATA_W-1:0];
  assign idx        = (NSLV > 1) ? head_addr[SEL_LSB +: IDX_W] : '0;

  assign done  = (state_q == ST_ACCESS) && Pready;
  assign abort = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !Pready && (wait_cnt_q == WC_LAST);

  // A full FIFO still takes a beat when the head leaves in the same cycle
  assign pop  = (state_d == ST_SETUP);
  assign push = valid && (!full || pop);

  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + CNT_ONE;
    else if (pop && !push) count_nxt = fifo_count - CNT_ONE;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!empty) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (done || abort) state_d = empty ? ST_IDLE : ST_SETUP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_d     = psel_q;
    penable_d  = 1'b0;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    hrdata_d   = hrdata_q;
    rd_valid_d = 1'b0;
    hresp_d    = HRESP_OKAY;
    wait_cnt_d = wait_cnt_q;
    hready_d   = (count_nxt < HR_LIM);
    overflow_d = overflow_q | (valid && full && !pop);

    if (state_q == ST_ACCESS && !Pready) wait_cnt_d = wait_cnt_q + WC_ONE;

    if (done) begin
      if (!pwrite_q) begin
        hrdata_d   = Prdata;
        rd_valid_d = 1'b1;
      end
      if (Pslverr) hresp_d = HRESP_ERROR;
    end
    if (abort) hresp_d = HRESP_ERROR;

    case (state_d)
      ST_IDLE: psel_d = '0;
      ST_SETUP: begin
        psel_d      = '0;
        psel_d[idx] = 1'b1;
        pwrite_d    = head_write;
        paddr_d     = head_addr;
        pwdata_d    = head_data;
        wait_cnt_d  = '0;
      end
      ST_ACCESS: penable_d = 1'b1;
      default: psel_d = '0;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      hrdata_q   <= '0;
      rd_valid_q <= 1'b0;
      hresp_q    <= HRESP_OKAY;
      wait_cnt_q <= '0;
      hready_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      hrdata_q   <= hrdata_d;
      rd_valid_q <= rd_valid_d;
      hresp_q    <= hresp_d;
      wait_cnt_q <= wait_cnt_d;
      hready_q   <= hready_d;
      overflow_q <= overflow_d;
    end
  end

  assign Psel       = psel_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign Hrdata     = hrdata_q;
  assign rd_valid   = rd_valid_q;
  assign Hresp      = hresp_q;
  assign Hready_out = hready_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: table of single transfers plus hand-written
// sequences for error chaining, timeout, burst back-pressure and mid-transfer reset.
module tb_apb_controller;

  logic        Hclk, Hresetn, valid, Hwrite_temp, Pready, Pslverr;
  logic [31:0] Haddr_temp, Hwdata_temp, Prdata;
  logic [3:0]  Psel;
  logic        Penable, Pwrite, rd_valid, Hresp, Hready_out, overflow;
  logic [31:0] Paddr, Pwdata, Hrdata;

  int n_tests = 0;
  int n_fail  = 0;

  apb_controller dut (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .valid       (valid),
    .Haddr_temp  (Haddr_temp),
    .Hwdata_temp (Hwdata_temp),
    .Hwrite_temp (Hwrite_temp),
    .Prdata      (Prdata),
    .Pready      (Pready),
    .Pslverr     (Pslverr),
    .Psel        (Psel),
    .Penable     (Penable),
    .Pwrite      (Pwrite),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata),
    .Hrdata      (Hrdata),
    .rd_valid    (rd_valid),
    .Hresp       (Hresp),
    .Hready_out  (Hready_out),
    .overflow    (overflow)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    logic [3:0]  exp_psel;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    valid = 1'b1; Haddr_temp = v.addr; Hwdata_temp = v.wdata; Hwrite_temp = v.wr;
    Pready = 1'b0; Pslverr = 1'b0;
    tick();
    valid = 1'b0;
    check($sformatf("v%0d psel_idle", k), 32'(Psel), 32'h0);
    tick();
    check($sformatf("v%0d psel_setup", k), 32'(Psel), 32'(v.exp_psel));
    check($sformatf("v%0d penable_setup", k), 32'(Penable), 32'h0);
    check($sformatf("v%0d paddr", k), Paddr, v.addr);
    check($sformatf("v%0d pwrite", k), 32'(Pwrite), 32'(v.wr));
    check($sformatf("v%0d pwdata", k), Pwdata, v.wdata);
    tick();
    check($sformatf("v%0d penable_access", k), 32'(Penable), 32'h1);
    check($sformatf("v%0d psel_access", k), 32'(Psel), 32'(v.exp_psel));
    for (int i = 0; i < v.waits; i++) begin
      tick();
      check($sformatf("v%0d penable_wait%0d", k, i), 32'(Penable), 32'h1);
      check($sformatf("v%0d psel_wait%0d", k, i), 32'(Psel), 32'(v.exp_psel));
      check($sformatf("v%0d pulse_wait%0d", k, i), {30'h0, rd_valid, Hresp}, 32'h0);
    end
    Pready = 1'b1; Pslverr = v.slverr; Prdata = v.prdata;
    tick();
    check($sformatf("v%0d psel_done", k), 32'(Psel), 32'h0);
    check($sformatf("v%0d penable_done", k), 32'(Penable), 32'h0);
    check($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'(!v.wr));
    check($sformatf("v%0d hresp", k), 32'(Hresp), 32'(v.slverr));
    check($sformatf("v%0d hrdata", k), Hrdata, v.exp_hrdata);
    check($sformatf("v%0d paddr_hold", k), Paddr, v.addr);
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    tick();
    check($sformatf("v%0d pulses_clear", k), {30'h0, rd_valid, Hresp}, 32'h0);
    check($sformatf("v%0d hrdata_hold", k), Hrdata, v.exp_hrdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          pen_cyc[$];
    logic [31:0] done_addr[$];

    //          wr    addr          wdata         prdata        err  w  psel     hrdata
    vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        1'b0, 0, 4'b0010, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         32'h1234_5678, 1'b0, 2, 4'b1000, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'h0BAD_F00D, 32'h0,        1'b1, 1, 4'b0001, 32'h1234_5678};
    vecs[3] = '{1'b0, 32'h2000_0008, 32'h0,         32'hCAFE_F00D, 1'b1, 0, 4'b0100, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h1FFF_FFFC, 32'h0,         32'hA5A5_A5A5, 1'b0, 3, 4'b0010, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 32'hF000_0000, 32'h55AA_55AA, 32'h0,        1'b0, 0, 4'b1000, 32'hA5A5_A5A5};

    Hresetn = 1'b0; valid = 1'b0; Haddr_temp = '0; Hwdata_temp = '0; Hwrite_temp = 1'b0;
    Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
    #22;
    check("rst psel", 32'(Psel), 32'h0);
    check("rst penable", 32'(Penable), 32'h0);
    check("rst hready", 32'(Hready_out), 32'h1);
    check("rst pulses_ovf", {29'h0, rd_valid, Hresp, overflow}, 32'h0);
    check("rst hrdata", Hrdata, 32'h0);
    check("rst paddr", Paddr, 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Error on a write must not block the beat queued behind it
    Pready = 1'b0;
    valid = 1'b1; Haddr_temp = 32'h0000_0040; Hwdata_temp = 32'h1111_1111; Hwrite_temp = 1'b1;
    tick();
    Haddr_temp = 32'h2000_0010; Hwdata_temp = 32'h0; Hwrite_temp = 1'b0;
    tick();
    valid = 1'b0;
    check("err psel_a", 32'(Psel), 32'h1);
    tick();
    check("err penable_a", 32'(Penable), 32'h1);
    Pready = 1'b1; Pslverr = 1'b1;
    tick();
    check("err hresp", 32'(Hresp), 32'h1);
    check("err rd_valid_a", 32'(rd_valid), 32'h0);
    check("err psel_b", 32'(Psel), 32'h4);
    check("err penable_b_setup", 32'(Penable), 32'h0);
    check("err paddr_b", Paddr, 32'h2000_0010);
    Pslverr = 1'b0; Prdata = 32'h0F0F_0F0F;
    tick();
    check("err hresp_clear", 32'(Hresp), 32'h0);
    check("err penable_b", 32'(Penable), 32'h1);
    tick();
    check("err rd_valid_b", 32'(rd_valid), 32'h1);
    check("err hresp_b", 32'(Hresp), 32'h0);
    check("err hrdata_b", Hrdata, 32'h0F0F_0F0F);
    check("err psel_idle", 32'(Psel), 32'h0);
    Pready = 1'b0; Prdata = '0;
    tick();

    // Timeout: 16 ACCESS cycles without Pready then abort
    valid = 1'b1; Haddr_temp = 32'h1000_0000; Hwrite_temp = 1'b0;
    tick();
    valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("tmo still_access%0d", i), 32'(Penable), 32'h1);
      check($sformatf("tmo no_pulse%0d", i), 32'(Hresp), 32'h0);
    end
    tick();
    check("tmo hresp", 32'(Hresp), 32'h1);
    check("tmo rd_valid", 32'(rd_valid), 32'h0);
    check("tmo penable", 32'(Penable), 32'h0);
    check("tmo psel", 32'(Psel), 32'h0);
    check("tmo hrdata_hold", Hrdata, 32'h0F0F_0F0F);
    tick();
    check("tmo hresp_clear", 32'(Hresp), 32'h0);
    check("tmo idle", 32'(Psel), 32'h0);

    // Burst: 9 back-to-back beats, 9th arrives while full with no pop
    for (int c = 1; c <= 26; c++) begin
      if (c <= 9) begin
        valid = 1'b1; Haddr_temp = 32'h10 * c; Hwdata_temp = 32'(c); Hwrite_temp = 1'b1;
      end else valid = 1'b0;
      Pready = 1'b1;
      tick();
      if (c <= 9) check($sformatf("burst hready_e%0d", c), 32'(Hready_out), 32'(c <= 4));
      if (c == 8) check("burst ovf_before", 32'(overflow), 32'h0);
      if (c == 9) check("burst ovf_set", 32'(overflow), 32'h1);
      if (Penable) begin
        done_addr.push_back(Paddr);
        pen_cyc.push_back(c);
      end
    end
    Pready = 1'b0;
    check("burst n_xfers", 32'(done_addr.size()), 32'd8);
    for (int i = 0; i < done_addr.size() && i < 8; i++)
      check($sformatf("burst addr%0d", i), done_addr[i], 32'h10 * (i + 1));
    for (int i = 1; i < pen_cyc.size(); i++)
      check($sformatf("burst spacing%0d", i), 32'(pen_cyc[i] - pen_cyc[i-1]), 32'd2);
    check("burst ovf_sticky", 32'(overflow), 32'h1);
    check("burst hready_back", 32'(Hready_out), 32'h1);

    // Reset in the middle of ACCESS with more beats queued
    valid = 1'b1; Hwrite_temp = 1'b0; Haddr_temp = 32'h1000_0020;
    tick();
    Haddr_temp = 32'h2000_0020;
    tick();
    Haddr_temp = 32'h3000_0020;
    tick();
    valid = 1'b0;
    tick();
    check("rstmid in_access", 32'(Penable), 32'h1);
    #2;
    Hresetn = 1'b0;
    #1;
    check("rstmid psel", 32'(Psel), 32'h0);
    check("rstmid penable", 32'(Penable), 32'h0);
    check("rstmid hready", 32'(Hready_out), 32'h1);
    check("rstmid ovf", 32'(overflow), 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();
    check("rstmid no_pulse", {30'h0, rd_valid, Hresp}, 32'h0);
    check("rstmid flushed1", 32'(Psel), 32'h0);
    tick();
    check("rstmid flushed2", {27'h0, Psel, Penable}, 32'h0);

    run_vec(vecs[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
